// File: rtl/memory_access_stage.sv
// Y86-64 memory stage: one 64-bit data access per instruction over req/ready.
// Optional DMEM_TIMEOUT_EN bounds the wait with an error completion.
module memory_access_stage #(
    parameter logic [63:0] ADDR_MAX       = 64'h0000_0000_0000_1FFF,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  M_stat_i,
    input  logic [3:0]  M_icode_i,
    input  logic [63:0] M_valE_i,
    input  logic [63:0] M_valA_i,
    input  logic        m_adv_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [63:0] dmem_addr_o,
    output logic [63:0] dmem_wdata_o,
    input  logic        dmem_ready_i,
    input  logic [63:0] dmem_rdata_i,
    input  logic        dmem_err_i,
    output logic [63:0] m_valM_o,
    output logic [2:0]  m_stat_o,
    output logic        m_stall_o
);

    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [2:0] S_AOK    = 3'd1;
    localparam logic [2:0] S_ADR    = 3'd3;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] valm_q;
    logic [2:0]  stat_q;
    logic        cap_en;

    logic        is_rd, is_wr, stack_rd;
    logic        memop, adr_err, go, timeout;
    logic [63:0] addr;
    logic [64:0] addr_end;

    assign is_rd    = (M_icode_i == I_MRMOVQ) || (M_icode_i == I_POPQ)
                   || (M_icode_i == I_RET);
    assign is_wr    = (M_icode_i == I_RMMOVQ) || (M_icode_i == I_PUSHQ)
                   || (M_icode_i == I_CALL);
    assign stack_rd = (M_icode_i == I_POPQ) || (M_icode_i == I_RET);
    assign memop    = (is_rd || is_wr) && (M_stat_i == S_AOK);
    assign addr     = stack_rd ? M_valA_i : M_valE_i;

    // 65-bit sum so a wrap past 2^64 is caught as out of range
    assign addr_end = {1'b0, addr} + 65'd7;
    assign adr_err  = memop && (addr_end > {1'b0, ADDR_MAX});
    assign go       = memop && !adr_err;

    assign dmem_we_o    = is_wr;
    assign dmem_addr_o  = addr;
    assign dmem_wdata_o = M_valA_i;

`ifdef DMEM_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8)
                      ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    assign timeout = (state_q == WAIT) && (cnt_q == TO_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i || state_q != WAIT) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        dmem_req_o = 1'b0;
        m_stall_o  = 1'b0;
        m_valM_o   = '0;
        m_stat_o   = M_stat_i;
        cap_en     = 1'b0;
        unique case (state_q)
            IDLE, WAIT: begin
                if (adr_err) begin
                    m_stat_o = S_ADR;
                end
                if (go && timeout) begin
                    m_stat_o = S_ADR;
                    cap_en   = 1'b1;
                    state_d  = m_adv_i ? IDLE : DONE;
                end else if (go) begin
                    dmem_req_o = 1'b1;
                    if (dmem_ready_i) begin
                        m_valM_o = is_rd ? dmem_rdata_i : '0;
                        m_stat_o = dmem_err_i ? S_ADR : M_stat_i;
                        cap_en   = 1'b1;
                        state_d  = m_adv_i ? IDLE : DONE;
                    end else begin
                        m_stall_o = 1'b1;
                        state_d   = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                m_valM_o = valm_q;
                m_stat_o = stat_q;
                if (m_adv_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst_i) begin
            dmem_req_o = 1'b0;
            m_stall_o  = 1'b0;
            m_valM_o   = '0;
            m_stat_o   = M_stat_i;
            cap_en     = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            valm_q  <= '0;
            stat_q  <= '0;
        end else begin
            state_q <= state_d;
            if (cap_en) begin
                valm_q <= m_valM_o;
                stat_q <= m_stat_o;
            end
        end
    end

endmodule
